fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline. It is the producer side of the IF/ID interface that `decode_stage` consumes: it owns the fetch PC and issues one-outstanding-request reads to instruction memory. It absorbs responses in a one-entry buffer and drives the IF/ID pipeline register (`instr`, `pc`, `pc4`) under stall, flush and branch/jump redirect from the hazard unit and the execute stage.

---
 rtl/fetch_stage.sv | 187 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I fetch. Owns the fetch PC and keeps one imem read in flight.
//            Responses land in IF/ID or a one-entry buffer. Stall, flush and
//            EX redirect are honoured. Define FETCH_PERF_EN for the
//            o_fetch_cnt/o_drop_cnt counters.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall_d,
  input  logic                  i_flush_d,
  input  logic                  i_pcsrc_e,
  input  logic [DATA_WIDTH-1:0] i_pc_target_e,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ready,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_instr_d,
  output logic [DATA_WIDTH-1:0] o_pc_d,
  output logic [DATA_WIDTH-1:0] o_pc4_d,
`ifdef FETCH_PERF_EN
  output logic [31:0]           o_fetch_cnt,
  output logic [15:0]           o_drop_cnt,
`endif
  output logic                  o_valid_d
);

  localparam logic [DATA_WIDTH-1:0] C_NOP  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] C_FOUR = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] pc4d_q, pc4d_d;
  logic                  valid_q, valid_d;

  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + C_FOUR;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= '0;
      instr_q <= C_NOP;
      pcd_q   <= '0;
      pc4d_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4d_q  <= pc4d_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    buf_d     = buf_q;
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pc4d_d    = pc4d_q;
    valid_d   = valid_q;
    load      = 1'b0;
    load_data = buf_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (i_imem_ready) begin
          state_d = S_WAIT;
          // The request just accepted fetches the old path
          if (i_pcsrc_e) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (drop_q || i_pcsrc_e) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (!i_stall_d && !i_flush_d) begin
            load      = 1'b1;
            load_data = i_imem_rdata;
            state_d   = S_REQ;
          end else begin
            buf_d   = i_imem_rdata;
            state_d = S_FULL;
          end
        end else if (i_pcsrc_e) begin
          drop_d = 1'b1;
        end
      end
      S_FULL: begin
        if (i_pcsrc_e) begin
          state_d = S_REQ;
        end else if (!i_stall_d && !i_flush_d) begin
          // A flush blanks IF/ID but the buffered word stays for later
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_pcsrc_e) begin
      pc_d = i_pc_target_e;
    end else if (load) begin
      pc_d = pc_plus4;
    end

    if (i_flush_d) begin
      instr_d = C_NOP;
      pcd_d   = '0;
      pc4d_d  = '0;
      valid_d = 1'b0;
    end else if (!i_stall_d && load) begin
      instr_d = load_data;
      pcd_d   = pc_q;
      pc4d_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  assign o_imem_req  = (state_q == S_REQ);
  assign o_imem_addr = pc_q;
  assign o_instr_d   = instr_q;
  assign o_pc_d      = pcd_q;
  assign o_pc4_d     = pc4d_q;
  assign o_valid_d   = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_evt;

  // Wrong-path responses and buffered words killed by a redirect both count
  assign drop_evt = ((state_q == S_WAIT) && i_imem_rvalid && (drop_q || i_pcsrc_e)) ||
                    ((state_q == S_FULL) && i_pcsrc_e);

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, load};
    drop_cnt_d  = drop_cnt_q + {15'd0, drop_evt};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed scenarios, then a
//            randomized run against an event-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, pcsrc, ready, rvalid;
  logic [31:0] target, rdata;
  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pc4_d;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [15:0] drop_cnt;
`endif

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall_d     (stall),
    .i_flush_d     (flush),
    .i_pcsrc_e     (pcsrc),
    .i_pc_target_e (target),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ready  (ready),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_instr_d     (instr_d),
    .o_pc_d        (pc_d),
    .o_pc4_d       (pc4_d),
`ifdef FETCH_PERF_EN
    .o_fetch_cnt   (fetch_cnt),
    .o_drop_cnt    (drop_cnt),
`endif
    .o_valid_d     (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [129:0] obs;
  logic [129:0] exp_v;
  assign obs = {imem_req, imem_addr, instr_d, pc_d, pc4_d, valid_d};

  function automatic logic [129:0] exp_vec(input logic req, input logic [31:0] a,
                                           input logic [31:0] i, input logic [31:0] p,
                                           input logic [31:0] p4, input logic v);
    return {req, a, i, p, p4, v};
  endfunction

  // Reference model: tracks "a read is in flight", "a word is parked",
  // "the in-flight read is wrong-path" and the IF/ID contents.
  logic        m_started, m_out, m_hasbuf, m_wrong, m_valid;
  logic [31:0] m_buf, m_pc, m_instr, m_pcd, m_pc4d, m_fetch;
  logic [15:0] m_drop;

  function automatic logic model_req();
    return m_started && !m_out && !m_hasbuf;
  endfunction

  task automatic model_reset();
    m_started = 0; m_out = 0; m_hasbuf = 0; m_wrong = 0; m_buf = 0;
    m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
    m_fetch = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic acc, resp, discard, take, park, unpark, kill;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc     = model_req() && ready;
    resp    = m_out && rvalid;
    discard = resp && (m_wrong || pcsrc);
    take    = resp && !discard && !stall && !flush;
    park    = resp && !discard && (stall || flush);
    unpark  = m_hasbuf && !pcsrc && !stall && !flush;
    kill    = m_hasbuf && pcsrc;
    if (flush) begin
      m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
    end else if (take || unpark) begin
      m_instr = take ? rdata : m_buf;
      m_pcd   = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1;
    end
    if (take || unpark) m_fetch = m_fetch + 1;
    if (discard || kill) m_drop = m_drop + 1;
    if (resp) m_wrong = 0;
    else if ((acc || m_out) && pcsrc) m_wrong = 1;
    if (park) begin m_hasbuf = 1; m_buf = rdata; end
    else if (unpark || kill) m_hasbuf = 0;
    m_out     = acc ? 1'b1 : (resp ? 1'b0 : m_out);
    m_pc      = pcsrc ? target : ((take || unpark) ? m_pc + 32'd4 : m_pc);
    m_started = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; pcsrc = 0; target = 0; ready = 0; rvalid = 0; rdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    tick(); tick();
    exp_v = exp_vec(0, RST_PC, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL reset_values: got %h want %h", obs, exp_v); else n_pass++;
    rst_n = 1;
    tick();
    exp_v = exp_vec(1, RST_PC, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL first_req: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_basic();
    ready = 1; tick();
    exp_v = exp_vec(0, 32'h0, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL accept_wait: got %h want %h", obs, exp_v); else n_pass++;
    ready = 0; rvalid = 1; rdata = 32'h0050_0113; tick();
    rvalid = 0;
    exp_v = exp_vec(1, 32'h4, 32'h0050_0113, 32'h0, 32'h4, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL basic_load: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_stall();
    ready = 1; tick();
    ready = 0; stall = 1; rvalid = 1; rdata = 32'h00C0_0193; tick();
    rvalid = 0;
    exp_v = exp_vec(0, 32'h4, 32'h0050_0113, 32'h0, 32'h4, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL stall_buffer: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    n_chk++; if (obs !== exp_v) $display("FAIL stall_hold: got %h want %h", obs, exp_v); else n_pass++;
    stall = 0; tick();
    exp_v = exp_vec(1, 32'h8, 32'h00C0_0193, 32'h4, 32'h8, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL stall_release: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_redirect();
    ready = 1; tick();
    ready = 0; pcsrc = 1; target = 32'h100; tick();
    pcsrc = 0;
    exp_v = exp_vec(0, 32'h100, 32'h00C0_0193, 32'h4, 32'h8, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL redirect_wait: got %h want %h", obs, exp_v); else n_pass++;
    rvalid = 1; rdata = $urandom; tick();
    rvalid = 0;
    exp_v = exp_vec(1, 32'h100, 32'h00C0_0193, 32'h4, 32'h8, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL redirect_drop: got %h want %h", obs, exp_v); else n_pass++;
`ifdef FETCH_PERF_EN
    n_chk++; if (drop_cnt !== 16'd1 || fetch_cnt !== 32'd2)
      $display("FAIL perf_counts: got drop=%0d fetch=%0d want drop=1 fetch=2", drop_cnt, fetch_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_flush_stall();
    flush = 1; stall = 1; tick();
    flush = 0; stall = 0;
    exp_v = exp_vec(1, 32'h100, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL flush_stall_bubble: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_ready_hold();
    ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_v = exp_vec(1, 32'h100, NOP, 0, 0, 0);
      n_chk++; if (obs !== exp_v) $display("FAIL ready_hold[%0d]: got %h want %h", k, obs, exp_v); else n_pass++;
    end
    ready = 1; tick();
    ready = 0;
    exp_v = exp_vec(0, 32'h100, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL ready_accept: got %h want %h", obs, exp_v); else n_pass++;
    rvalid = 1; rdata = 32'h0000_0297; tick();
    rvalid = 0;
    exp_v = exp_vec(1, 32'h104, 32'h0000_0297, 32'h100, 32'h104, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL target_load: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_wrap();
    pcsrc = 1; target = 32'hFFFF_FFFC; tick();
    pcsrc = 0;
    exp_v = exp_vec(1, 32'hFFFF_FFFC, 32'h0000_0297, 32'h100, 32'h104, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL redirect_req: got %h want %h", obs, exp_v); else n_pass++;
    ready = 1; tick();
    ready = 0; rvalid = 1; rdata = 32'h0000_0073; tick();
    rvalid = 0;
    exp_v = exp_vec(1, 32'h0, 32'h0000_0073, 32'hFFFF_FFFC, 32'h0, 1);
    n_chk++; if (obs !== exp_v) $display("FAIL pc_wrap: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_reset_mid();
    ready = 1; tick();
    ready = 0;
    rst_n = 0;
    #2;
    exp_v = exp_vec(0, RST_PC, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL async_reset: got %h want %h", obs, exp_v); else n_pass++;
`ifdef FETCH_PERF_EN
    n_chk++; if (drop_cnt !== 16'd0 || fetch_cnt !== 32'd0)
      $display("FAIL perf_reset: got drop=%0d fetch=%0d want 0 0", drop_cnt, fetch_cnt);
    else n_pass++;
`endif
    model_reset();
    tick();
    rst_n = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; tick();
    rvalid = 0;
    exp_v = exp_vec(1, RST_PC, NOP, 0, 0, 0);
    n_chk++; if (obs !== exp_v) $display("FAIL idle_rvalid_ignored: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      pcsrc  = ($urandom_range(0, 9) == 0);
      target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ready  = $urandom_range(0, 1);
      rvalid = m_out && ($urandom_range(0, 2) == 0);
      rdata  = $urandom;
      tick();
      exp_v = exp_vec(model_req(), m_pc, m_instr, m_pcd, m_pc4d, m_valid);
      n_chk++; if (obs !== exp_v) $display("FAIL random[%0d]: got %h want %h", c, obs, exp_v); else n_pass++;
`ifdef FETCH_PERF_EN
      n_chk++; if (drop_cnt !== m_drop || fetch_cnt !== m_fetch)
        $display("FAIL random_perf[%0d]: got drop=%0d fetch=%0d want drop=%0d fetch=%0d",
                 c, drop_cnt, fetch_cnt, m_drop, m_fetch);
      else n_pass++;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_ready_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
